// File: rtl/lsu_if.sv
// Memory-side bus between the load/store unit and the data memory.
// The LSU is the master; memory (or the bench) is the slave.
interface lsu_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// RV32 load/store unit: one aligned 32-bit bus transaction per memory op,
// with byte-lane steering, load extension and fault reporting.
module lsu #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_load,
  input  logic         is_store,
  input  logic [2:0]   funct3,
  input  logic [31:0]  address,
  input  logic [31:0]  store_data,
  lsu_if.master        mem,
  output logic [31:0]  load_data,
  output logic         done,
  output logic         busy,
  output logic [1:0]   fault
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_MISALGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  addr_lo;

  logic        op_any;
  logic        illegal;
  logic        misaligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_strb;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  // Request decode; a store wins when both is_load and is_store are set.
  always_comb begin
    op_any     = is_load | is_store;
    illegal    = 1'b0;
    misaligned = 1'b0;
    lane_wdata = store_data;
    lane_strb  = 4'b1111;
    if (is_store)
      illegal = funct3[2] | (funct3[1:0] == 2'b11);
    else
      illegal = (funct3[1:0] == 2'b11) | (funct3 == 3'b110);
    case (funct3[1:0])
      2'b01:   misaligned = address[0];
      2'b10:   misaligned = (address[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        lane_wdata = {4{store_data[7:0]}};
        lane_strb  = 4'b0001 << address[1:0];
      end
      2'b01: begin
        lane_wdata = {2{store_data[15:0]}};
        lane_strb  = address[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_wdata = store_data;
        lane_strb  = 4'b1111;
      end
    endcase
  end

  // Lane select and extension of returned read data.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0:    byte_sel = mem.mem_rdata[7:0];
      2'd1:    byte_sel = mem.mem_rdata[15:8];
      2'd2:    byte_sel = mem.mem_rdata[23:16];
      default: byte_sel = mem.mem_rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_data = {24'h000000, byte_sel};
      3'b101:  ext_data = {16'h0000, half_sel};
      default: ext_data = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      store_q       <= 1'b0;
      f3_q          <= 3'b000;
      addr_lo       <= 2'b00;
      mem.mem_valid <= 1'b0;
      mem.mem_addr  <= 32'h0;
      mem.mem_wdata <= 32'h0;
      mem.mem_wstrb <= 4'b0000;
      load_data     <= 32'h0;
      done          <= 1'b0;
      busy          <= 1'b0;
      fault         <= FAULT_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!op_any) begin
              state <= FIN;
              done  <= 1'b1;
              fault <= FAULT_NONE;
            end else if (illegal) begin
              state <= FIN;
              done  <= 1'b1;
              fault <= FAULT_ILLEGAL;
            end else if (misaligned) begin
              state <= FIN;
              done  <= 1'b1;
              fault <= FAULT_MISALGN;
            end else begin
              state         <= REQ;
              busy          <= 1'b1;
              wait_cnt      <= 8'd0;
              store_q       <= is_store;
              f3_q          <= funct3;
              addr_lo       <= address[1:0];
              mem.mem_valid <= 1'b1;
              mem.mem_addr  <= {address[31:2], 2'b00};
              mem.mem_wdata <= is_store ? lane_wdata : 32'h0;
              mem.mem_wstrb <= is_store ? lane_strb : 4'b0000;
            end
          end
        end
        REQ: begin
          if (mem.mem_ready) begin
            state         <= FIN;
            mem.mem_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            fault         <= FAULT_NONE;
            wait_cnt      <= 8'd0;
            if (!store_q)
              load_data <= ext_data;
          end else if (wait_cnt == WAIT_LAST) begin
            // This edge is the WAIT_LIMIT-th without ready: abandon the bus cycle.
            state         <= FIN;
            mem.mem_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            fault         <= FAULT_TIMEOUT;
            wait_cnt      <= 8'd0;
            if (!store_q)
              load_data <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; the bench plays the memory slave
// and the DUT is built with a short bus timeout.
module tb_lsu;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        done;
  logic        busy;
  logic [1:0]  fault;

  int checks;
  int failures;

  lsu_if bus ();

  lsu #(.WAIT_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .address    (address),
    .store_data (store_data),
    .mem        (bus),
    .load_data  (load_data),
    .done       (done),
    .busy       (busy),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start at a falling edge; returns after the accepting rising edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd);
    start      = 1'b1;
    is_load    = ld;
    is_store   = st;
    funct3     = f3;
    address    = addr;
    store_data = sd;
    @(negedge clk);
    start      = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'b000;
    address    = 32'h0;
    store_data = 32'h0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    start          = 1'b0;
    is_load        = 1'b0;
    is_store       = 1'b0;
    funct3         = 3'b000;
    address        = 32'h0;
    store_data     = 32'h0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = 32'h0;

    #12;
    chk("rst_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LB at 0x1003: top byte 0x80 sign-extends
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h80FF_1234;
    issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0);
    chk("lb_valid", 32'(bus.mem_valid), 32'd1);
    chk("lb_addr", bus.mem_addr, 32'h0000_1000);
    chk("lb_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("lb_busy", 32'(busy), 32'd1);
    chk("lb_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("lb_done", 32'(done), 32'd1);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    chk("lb_fault", 32'(fault), 32'd0);
    chk("lb_valid_drop", 32'(bus.mem_valid), 32'd0);
    chk("lb_busy_fin", 32'(busy), 32'd0);
    @(negedge clk);
    chk("lb_done_once", 32'(done), 32'd0);

    // LHU / LH at 0x2002
    bus.mem_rdata = 32'hBEEF_0000;
    issue(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0);
    @(negedge clk);
    chk("lhu_data", load_data, 32'h0000_BEEF);
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0);
    @(negedge clk);
    chk("lh_data", load_data, 32'hFFFF_BEEF);
    @(negedge clk);

    // Stores: lane replication and strobes
    issue(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB);
    chk("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    chk("sb_wstrb", 32'(bus.mem_wstrb), 32'b0010);
    chk("sb_addr", bus.mem_addr, 32'h0000_3000);
    @(negedge clk);
    chk("sb_done", 32'(done), 32'd1);
    @(negedge clk);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h0000_1234);
    chk("sh_wdata", bus.mem_wdata, 32'h1234_1234);
    chk("sh_wstrb", 32'(bus.mem_wstrb), 32'b1100);
    @(negedge clk);
    @(negedge clk);
    issue(1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
    chk("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("sw_wstrb", 32'(bus.mem_wstrb), 32'b1111);
    @(negedge clk);
    chk("sw_keep_load", load_data, 32'hFFFF_BEEF);
    @(negedge clk);

    // Fault paths complete one cycle after start without a bus cycle
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'h0);
    chk("lw_mis_valid", 32'(bus.mem_valid), 32'd0);
    chk("lw_mis_done", 32'(done), 32'd1);
    chk("lw_mis_fault", 32'(fault), 32'b01);
    chk("lw_mis_keep", load_data, 32'hFFFF_BEEF);
    @(negedge clk);
    issue(1'b0, 1'b1, 3'b011, 32'h0000_5000, 32'h1);
    chk("st_ill_done", 32'(done), 32'd1);
    chk("st_ill_fault", 32'(fault), 32'b10);
    chk("st_ill_valid", 32'(bus.mem_valid), 32'd0);
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b110, 32'h0000_5000, 32'h0);
    chk("ld_ill_fault", 32'(fault), 32'b10);
    @(negedge clk);
    issue(1'b0, 1'b0, 3'b000, 32'h0000_5000, 32'h0);
    chk("nop_done", 32'(done), 32'd1);
    chk("nop_fault", 32'(fault), 32'b00);
    @(negedge clk);

    // Timeout: valid stays high four cycles, then fault 11 and load_data cleared
    bus.mem_ready = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("to_valid_hold", 32'(bus.mem_valid), 32'd1);
      chk("to_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("to_valid_last", 32'(bus.mem_valid), 32'd1);
    @(negedge clk);
    chk("to_valid_drop", 32'(bus.mem_valid), 32'd0);
    chk("to_done", 32'(done), 32'd1);
    chk("to_fault", 32'(fault), 32'b11);
    chk("to_load_clear", load_data, 32'h0);
    @(negedge clk);

    // Start during REQ is ignored
    bus.mem_rdata = 32'h1122_3344;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0);
    issue(1'b0, 1'b1, 3'b010, 32'h0000_8000, 32'hFFFF_FFFF);
    chk("ign_addr", bus.mem_addr, 32'h0000_7000);
    chk("ign_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("ign_busy", 32'(busy), 32'd1);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_data", load_data, 32'h1122_3344);
    @(negedge clk);
    chk("ign_single_valid", 32'(bus.mem_valid), 32'd0);
    chk("ign_single_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("ign_idle_valid", 32'(bus.mem_valid), 32'd0);

    // Async reset while the bus request is outstanding
    bus.mem_ready = 1'b0;
    issue(1'b1, 1'b0, 3'b000, 32'h0000_9000, 32'h0);
    chk("mid_valid", 32'(bus.mem_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.mem_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_valid", 32'(bus.mem_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the execute-stage ALU in the multi-cycle RV32 core.
- Takes the ALU-computed effective address and rs2 store data, and runs one aligned 32-bit bus transaction per memory instruction.
- Generates byte strobes and lane-replicated write data, and sign/zero-extends load data for writeback.
- Flags misaligned, illegal-width and bus-timeout faults to the control FSM.

Parameters:
- WAIT_LIMIT, 255: max cycles mem_valid stays high without mem_ready before a timeout fault (1..255).

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse from the control FSM (memory state)
- is_load  in  1  decoded load
- is_store  in  1  decoded store
- funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- address  in  32  effective address from the ALU
- store_data  in  32  rs2 value
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accept/complete
- mem_addr  out  32  word-aligned address {address[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes; 0000 for loads
- mem_rdata  in  32  read data, valid when mem_valid&&mem_ready
- load_data  out  32  extended load result
- done  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after start until done
- fault  out  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout; valid with done

Behaviour:
- Reset (async, rst_n=0): state IDLE.
- Reset values: mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, load_data=0, done=0, busy=0, fault=00, wait counter=0.
- Reset mid-transaction: mem_valid drops immediately; the transaction is abandoned.
- States: IDLE, REQ, FIN. All outputs are registered.
- IDLE, start=1 sampled at edge k:
  - Neither is_load nor is_store: go to FIN with fault=00.
  - Both asserted: treat as a store.
  - Store with funct3 not in {000,001,010}, or load with funct3 not in {000,001,010,100,101}: go to FIN with fault=10.
  - Misaligned access (H with address[0]=1; W with address[1:0]!=0): go to FIN with fault=01. No bus cycle is issued.
  - Otherwise: go to REQ. mem_valid=1 and addr/wdata/wstrb are driven from edge k and held stable through REQ.
- Store lanes:
  - SB: wdata={4{sd[7:0]}}, wstrb=0001<<address[1:0].
  - SH: wdata={2{sd[15:0]}}, wstrb=0011 (address[1]=0) or 1100.
  - SW: wdata=sd, wstrb=1111.
- REQ, mem_ready=1 at an edge: go to FIN and drop mem_valid. For a load, load_data is set at the same edge:
  - Select the byte at address[1:0] or the halfword at address[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- REQ, mem_ready=0: wait counter increments. When the counter reaches WAIT_LIMIT: drop mem_valid, go to FIN with fault=11, load_data=0.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. Counter clears on leaving REQ.
- Latency: with mem_ready tied high, start at edge k, ready sampled at edge k+1, done high after edge k+1. Fault paths: done high after edge k.
- load_data:
  - Changes only on a successful load, or is cleared on a load timeout.
  - Unchanged by stores and by misaligned/illegal faults.
- start while busy or in FIN: ignored.
- Inputs other than mem_ready/mem_rdata are sampled only at the accepting start edge.

Test Plan:
- LB at 0x1003, mem_rdata=0x80FF_1234, ready=1 -> mem_addr=0x1000, wstrb=0000, done 2 cycles after start, load_data=0xFFFF_FF80, fault=00.
- LHU at 0x2002, rdata=0xBEEF_0000 -> load_data=0x0000_BEEF; LH at the same address -> 0xFFFF_BEEF.
- SB 0xAB at 0x3001 -> wdata=0xABAB_ABAB, wstrb=0010; SH 0x1234 at 0x3002 -> wdata=0x1234_1234, wstrb=1100; SW -> wstrb=1111.
- LW at 0x4002 -> no mem_valid, done next cycle, fault=01, load_data unchanged. Store with funct3=011 -> fault=10.
- WAIT_LIMIT=4, load with mem_ready held low -> mem_valid high 4 cycles then low, done with fault=11, load_data=0.
- Second start pulse during REQ (ignored, single transaction); then rst_n low while mem_valid=1 -> mem_valid=0 immediately, busy=0, no done pulse.
